// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit holding the architectural HI/LO pair.
// Ports: clk/reset (sync, active-high); md_op/a/b/req = E-stage op, operands, flush;
//        start (comb accept of a multi-cycle op), busy (registered), hi/lo outputs.
// Optional: define MDU_MADD_EN to enable madd/maddu/msub/msubu (md_op 7-10).
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      phi;
  logic [31:0]      plo;

  // Op decode
  logic is_mul, is_div, is_signed, is_acc, is_sub, is_mthi, is_mtlo;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_acc    = 1'b0;
    is_sub    = 1'b0;
    is_mthi   = 1'b0;
    is_mtlo   = 1'b0;
    case (md_op)
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: begin is_mul = 1'b1; end
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  begin is_div = 1'b1; end
      OP_MTHI:  begin is_mthi = 1'b1; end
      OP_MTLO:  begin is_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default:  ;
    endcase
  end

  // Ops are only taken while idle; a flushed (req) op never takes effect.
  logic accept_ok;
  assign accept_ok = (state == S_IDLE) && !req;
  assign start     = accept_ok && (is_mul || is_div);
  assign busy      = (state == S_BUSY);

  // Multiply: operands extended to 64 bits so one unsigned multiplier gives the
  // correct low 64 bits for both signed and unsigned products.
  logic [63:0] ax, bx, prod, acc, mul_res;

  always_comb begin
    ax      = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    bx      = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod    = ax * bx;
    acc     = {hi, lo};
    mul_res = prod;
    if (is_acc) begin
      mul_res = is_sub ? (acc - prod) : (acc + prod);
    end
  end

  // Divide on magnitudes, then restore signs. This sidesteps the
  // 0x8000_0000 / -1 overflow: the magnitude quotient 0x8000_0000 is
  // positive-signed and stays 0x8000_0000 with remainder 0.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_den, uq, ur, div_hi, div_lo;

  always_comb begin
    neg_a   = is_signed & a[31];
    neg_b   = is_signed & b[31];
    mag_a   = neg_a ? (~a + 32'd1) : a;
    mag_b   = neg_b ? (~b + 32'd1) : b;
    div_den = (b == 32'd0) ? 32'd1 : mag_b;
    uq      = mag_a / div_den;
    ur      = mag_a % div_den;
    if (b == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = a;
    end else begin
      div_lo = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      div_hi = neg_a ? (~ur + 32'd1) : ur;
    end
  end

  // The result is computed at acceptance and parked in {phi,plo}; the counter
  // only models latency. hi/lo update on the edge that ends the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      phi   <= '0;
      plo   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state <= S_BUSY;
        cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        if (is_div) begin
          phi <= div_hi;
          plo <= div_lo;
        end else begin
          phi <= mul_res[63:32];
          plo <= mul_res[31:0];
        end
      end else if (accept_ok && is_mthi) begin
        hi <= a;
      end else if (accept_ok && is_mtlo) begin
        lo <= a;
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state <= S_IDLE;
        hi    <= phi;
        lo    <= plo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: checks mdu_hilo against a plain-arithmetic HI/LO model.
// Directed scenarios (mult, div by zero, signed div, mthi, flush, reset in flight,
// madd) followed by randomized back-to-back ops with junk input while busy.
module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_hilo dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .req   (req),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: what the architecture says {hi,lo} become and how long it takes.
  function automatic void model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                input logic rq, input logic [31:0] h, input logic [31:0] l,
                                output logic st, output int n,
                                output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sb, q, r;
    logic [63:0] p, accv;
    st = 1'b0; n = 0; nh = h; nl = l;
    if (rq) return;
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    accv = {h, l};
    case (op)
      4'd1: begin p = 64'(sa * sb); {nh, nl} = p; st = 1'b1; n = 5; end
      4'd2: begin p = {32'd0, av} * {32'd0, bv}; {nh, nl} = p; st = 1'b1; n = 5; end
      4'd3, 4'd4: begin
        st = 1'b1; n = 10;
        if (bv == 32'd0) begin
          nl = 32'hFFFF_FFFF; nh = av;
        end else if (op == 4'd3) begin
          q = sa / sb; r = sa % sb;
          nl = q[31:0]; nh = r[31:0];
        end else begin
          nl = av / bv; nh = av % bv;
        end
      end
      4'd5: nh = av;
      4'd6: nl = av;
`ifdef MDU_MADD_EN
      4'd7:  begin p = 64'(sa * sb); {nh, nl} = accv + p; st = 1'b1; n = 5; end
      4'd8:  begin p = {32'd0, av} * {32'd0, bv}; {nh, nl} = accv + p; st = 1'b1; n = 5; end
      4'd9:  begin p = 64'(sa * sb); {nh, nl} = accv - p; st = 1'b1; n = 5; end
      4'd10: begin p = {32'd0, av} * {32'd0, bv}; {nh, nl} = accv - p; st = 1'b1; n = 5; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op in the current cycle and follow it to retirement.
  // mode 0: idle inputs while busy; 1: random junk (ops/req) while busy;
  // 2: req plus a div presented in the second busy cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic rq, input int mode, input string tag);
    logic        exp_st;
    int          n;
    logic [31:0] nh, nl;
    model(op, av, bv, rq, m_hi, m_lo, exp_st, n, nh, nl);
    md_op = op; a = av; b = bv; req = rq;
    #1;
    total++;
    if (start !== exp_st) begin
      bad++;
      $display("FAIL %s start: got %b want %b", tag, start, exp_st);
    end
    tick;
    md_op = 4'd0; req = 1'b0;
    for (int k = 0; k < n; k++) begin
      total++;
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        bad++;
        $display("FAIL %s busy_cycle%0d: got busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                 tag, k + 1, busy, hi, lo, m_hi, m_lo);
      end
      if (mode == 1) begin
        md_op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        req = ($urandom_range(0, 1) == 0);
      end else if (mode == 2 && k == 1) begin
        md_op = 4'd3; a = 32'd99; b = 32'd4; req = 1'b1;
      end
      tick;
      md_op = 4'd0; req = 1'b0;
    end
    m_hi = nh; m_lo = nl;
    total++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL %s result: got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
               tag, busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; md_op = 4'd0; a = 32'd0; b = 32'd0; req = 1'b0;
    repeat (2) tick;
    total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || start !== 1'b0) begin
      bad++;
      $display("FAIL reset: got hi=%h lo=%h busy=%b start=%b want all zero", hi, lo, busy, start);
    end
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult;
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, "mult_neg2x3");
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      bad++;
      $display("FAIL mult_const: got hi=%h lo=%h want FFFFFFFF FFFFFFFA", hi, lo);
    end
  endtask

  task automatic test_div;
    run_op(4'd4, 32'd7, 32'd0, 1'b0, 0, "divu_by0");
    total++;
    if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL divu_by0_const: got hi=%h lo=%h want 00000007 FFFFFFFF", hi, lo);
    end
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, "div_neg7by2");
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_neg7_const: got hi=%h lo=%h want FFFFFFFF FFFFFFFD", hi, lo);
    end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_ovf");
    total++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL div_ovf_const: got hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
    run_op(4'd3, 32'd5, 32'd0, 1'b0, 0, "div_by0");
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] old_lo;
    old_lo = lo;
    run_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, 0, "mthi");
    total++;
    if (hi !== 32'h1234_5678 || lo !== old_lo || busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi_const: got hi=%h lo=%h busy=%b want 12345678 %h 0", hi, lo, busy, old_lo);
    end
    run_op(4'd6, 32'hCAFE_F00D, 32'd0, 1'b0, 0, "mtlo");
  endtask

  task automatic test_req;
    run_op(4'd3, 32'd100, 32'd7, 1'b1, 0, "div_flushed");
    run_op(4'd5, 32'hDEAD_0000, 32'd0, 1'b1, 0, "mthi_flushed");
    run_op(4'd1, 32'd1234, 32'hFFFF_0000, 1'b0, 2, "mult_req_inflight");
  endtask

  task automatic test_reset_inflight;
    md_op = 4'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; req = 1'b0;
    #1;
    total++;
    if (start !== 1'b1) begin
      bad++;
      $display("FAIL rst_inflight start: got %b want 1", start);
    end
    tick;
    md_op = 4'd0;
    repeat (2) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL rst_inflight: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    repeat (6) tick;
    total++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL rst_discard: got hi=%h lo=%h want 0 0", hi, lo);
    end
    run_op(4'd1, 32'd6, 32'hFFFF_FFF9, 1'b0, 0, "mult_after_reset");
  endtask

  task automatic test_madd;
    run_op(4'd5, 32'd0, 32'd0, 1'b0, 0, "madd_prep_hi");
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, "madd_prep_lo");
    run_op(4'd8, 32'd1, 32'd1, 1'b0, 0, "maddu_1x1");
`ifdef MDU_MADD_EN
    total++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      bad++;
      $display("FAIL maddu_const: got hi=%h lo=%h want 00000001 00000000", hi, lo);
    end
    run_op(4'd9, 32'd3, 32'd5, 1'b0, 0, "msub");
`else
    total++;
    if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL maddu_disabled: got hi=%h lo=%h want 00000000 FFFFFFFF", hi, lo);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op;
    logic [31:0] av, bv;
    logic        rq;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 9))
        0: bv = 32'd0;
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        2: bv = 32'($urandom_range(1, 9));
        default: ;
      endcase
      rq = ($urandom_range(0, 7) == 0);
      run_op(op, av, bv, rq, int'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mthi_mtlo;
    test_req;
    test_reset_inflight;
    test_madd;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
